// File: rtl/icache_if.sv
// Datapath/memory handshake bundle for the instruction cache, plus its performance counters.
// The cache takes the slave side; whoever drives requests and memory responses takes master.
interface icache_if #(
  parameter int CNT_W = 32
);
  logic             imemREN;
  logic [31:0]      imemaddr;
  logic             ihit;
  logic [31:0]      imemload;
  logic             iREN;
  logic [31:0]      iaddr;
  logic             iwait;
  logic [31:0]      iload;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits are served combinationally;
// misses latch the word address and fill from memory, with saturating hit/miss counters.
module icache #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic   CLK,
  input  logic   nRST,
  icache_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            r_state, w_state_next;
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [31:0]       r_data [SETS];
  logic [31:0]       r_miss_addr;
  logic [CNT_W-1:0]  r_hit_cnt, r_miss_cnt;

  logic [IDX_W-1:0]  w_idx, w_miss_idx;
  logic [TAG_W-1:0]  w_tag, w_miss_tag;
  logic              w_lookup_hit;
  logic              w_ihit, w_iren, w_fill, w_miss;
  logic [31:0]       w_imemload;
  logic              w_unused;

  assign w_idx      = bus.imemaddr[IDX_W+1:2];
  assign w_tag      = bus.imemaddr[31:IDX_W+2];
  assign w_miss_idx = r_miss_addr[IDX_W+1:2];
  assign w_miss_tag = r_miss_addr[31:IDX_W+2];
  assign w_unused   = ^{bus.imemaddr[1:0], r_miss_addr[1:0]};

  // valid is checked first so never-written tag/data entries cannot leak into a hit.
  assign w_lookup_hit = bus.imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  always_comb begin
    w_state_next = r_state;
    w_ihit       = 1'b0;
    w_imemload   = 32'h0;
    w_iren       = 1'b0;
    w_fill       = 1'b0;
    w_miss       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_lookup_hit) begin
          w_ihit     = 1'b1;
          w_imemload = r_data[w_idx];
        end else if (bus.imemREN) begin
          w_miss       = 1'b1;
          w_state_next = FETCH;
        end
      end
      FETCH: begin
        w_iren = bus.imemREN;
        if (!bus.imemREN) begin
          w_state_next = IDLE;
        end else if (!bus.iwait) begin
          w_fill       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_miss_addr <= 32'h0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_miss) begin
        r_miss_addr <= {bus.imemaddr[31:2], 2'b00};
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if (w_ihit && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_fill) r_valid[w_miss_idx] <= 1'b1;
    end
  end

  // Tag/data arrays are not reset; the fill always targets the latched miss line.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= bus.iload;
    end
  end

  assign bus.ihit       = w_ihit;
  assign bus.imemload   = w_imemload;
  assign bus.iREN       = w_iren;
  assign bus.iaddr      = r_miss_addr;
  assign bus.hit_count  = r_hit_cnt;
  assign bus.miss_count = r_miss_cnt;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache (SETS=16, CNT_W=4): miss/fill, conflict, abort,
// address change during fill, counter saturation and asynchronous reset mid-fetch.
module tb_icache;
  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_pass;
  int   exp_hit;
  int   exp_miss;

  icache_if #(.CNT_W(4)) bus ();

  icache #(.SETS(16), .CNT_W(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int sat(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_fill(input logic [31:0] addr, input logic [31:0] data, input int waits);
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.iwait    = 1'b1;
    tick();
    exp_miss++;
    repeat (waits) tick();
    bus.iwait = 1'b0;
    bus.iload = data;
    tick();
    bus.imemREN = 1'b0;
    bus.iwait   = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    nRST         = 1'b0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    bus.iwait    = 1'b1;
    bus.iload    = 32'hDEAD_BEEF;
    #12;
    n_checks++; if (bus.ihit !== 1'b0) $display("FAIL reset_ihit got %0h exp 0", bus.ihit); else n_pass++;
    n_checks++; if (bus.imemload !== 32'h0) $display("FAIL reset_imemload got %08h exp 0", bus.imemload); else n_pass++;
    n_checks++; if (bus.iREN !== 1'b0) $display("FAIL reset_iREN got %0h exp 0", bus.iREN); else n_pass++;
    n_checks++; if (bus.iaddr !== 32'h0) $display("FAIL reset_iaddr got %08h exp 0", bus.iaddr); else n_pass++;
    n_checks++; if (bus.hit_count !== 4'd0 || bus.miss_count !== 4'd0)
      $display("FAIL reset_counters got %0d/%0d exp 0/0", bus.hit_count, bus.miss_count); else n_pass++;
    bus.imemREN = 1'b0;
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_miss_fill();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0040;
    bus.iwait    = 1'b1;
    #1;
    n_checks++; if (bus.ihit !== 1'b0) $display("FAIL miss_ihit got %0h exp 0", bus.ihit); else n_pass++;
    tick();
    exp_miss++;
    n_checks++; if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h40)
      $display("FAIL miss_req got iREN=%0h iaddr=%08h exp 1/00000040", bus.iREN, bus.iaddr); else n_pass++;
    n_checks++; if (bus.miss_count !== 4'(sat(exp_miss)))
      $display("FAIL miss_count1 got %0d exp %0d", bus.miss_count, sat(exp_miss)); else n_pass++;
    tick();
    tick();
    bus.iwait = 1'b0;
    bus.iload = 32'h2001_0005;
    #1;
    n_checks++; if (bus.iREN !== 1'b1 || bus.ihit !== 1'b0)
      $display("FAIL fill_cycle got iREN=%0h ihit=%0h exp 1/0", bus.iREN, bus.ihit); else n_pass++;
    tick();
    bus.iwait = 1'b1;
    #1;
    n_checks++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'h2001_0005)
      $display("FAIL fill_hit got ihit=%0h load=%08h exp 1/20010005", bus.ihit, bus.imemload); else n_pass++;
    n_checks++; if (bus.iREN !== 1'b0) $display("FAIL fill_iREN got %0h exp 0", bus.iREN); else n_pass++;
    tick();
    exp_hit++;
    bus.imemREN = 1'b0;
    #1;
    n_checks++; if (bus.hit_count !== 4'(sat(exp_hit)))
      $display("FAIL hit_count1 got %0d exp %0d", bus.hit_count, sat(exp_hit)); else n_pass++;
  endtask

  task automatic test_conflict();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0080;
    #1;
    n_checks++; if (bus.ihit !== 1'b0) $display("FAIL conflict_80_miss got %0h exp 0", bus.ihit); else n_pass++;
    do_fill(32'h80, 32'hAAAA_0080, 0);
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h80;
    #1;
    n_checks++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'hAAAA_0080)
      $display("FAIL conflict_80_hit got ihit=%0h load=%08h exp 1/aaaa0080", bus.ihit, bus.imemload); else n_pass++;
    tick();
    exp_hit++;
    bus.imemaddr = 32'h40;
    #1;
    n_checks++; if (bus.ihit !== 1'b0) $display("FAIL conflict_40_replaced got %0h exp 0", bus.ihit); else n_pass++;
    do_fill(32'h40, 32'h2001_0005, 1);
    n_checks++; if (bus.miss_count !== 4'(sat(exp_miss)))
      $display("FAIL conflict_miss_count got %0d exp %0d", bus.miss_count, sat(exp_miss)); else n_pass++;
  endtask

  task automatic test_abort();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h44;
    bus.iwait    = 1'b1;
    tick();
    exp_miss++;
    n_checks++; if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h44)
      $display("FAIL abort_req got iREN=%0h iaddr=%08h exp 1/00000044", bus.iREN, bus.iaddr); else n_pass++;
    bus.imemREN = 1'b0;
    #1;
    n_checks++; if (bus.iREN !== 1'b0) $display("FAIL abort_iREN_drop got %0h exp 0", bus.iREN); else n_pass++;
    tick();
    bus.imemREN = 1'b1;
    bus.iwait   = 1'b0;
    #1;
    n_checks++; if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0)
      $display("FAIL abort_idle_miss got ihit=%0h iREN=%0h exp 0/0", bus.ihit, bus.iREN); else n_pass++;
    n_checks++; if (bus.miss_count !== 4'(sat(exp_miss)))
      $display("FAIL abort_miss_count got %0d exp %0d", bus.miss_count, sat(exp_miss)); else n_pass++;
    bus.imemREN = 1'b0;
    tick();
  endtask

  task automatic test_addr_change();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h48;
    bus.iwait    = 1'b1;
    tick();
    exp_miss++;
    bus.imemaddr = 32'h4C;
    #1;
    n_checks++; if (bus.iaddr !== 32'h48) $display("FAIL chg_iaddr_hold got %08h exp 00000048", bus.iaddr); else n_pass++;
    tick();
    bus.iwait = 1'b0;
    bus.iload = 32'h4848_4848;
    tick();
    bus.iwait = 1'b1;
    #1;
    n_checks++; if (bus.ihit !== 1'b0) $display("FAIL chg_4C_miss got %0h exp 0", bus.ihit); else n_pass++;
    tick();
    exp_miss++;
    n_checks++; if (bus.iaddr !== 32'h4C || bus.iREN !== 1'b1)
      $display("FAIL chg_4C_req got iaddr=%08h iREN=%0h exp 0000004c/1", bus.iaddr, bus.iREN); else n_pass++;
    bus.imemREN = 1'b0;
    tick();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h48;
    #1;
    n_checks++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'h4848_4848)
      $display("FAIL chg_48_hit got ihit=%0h load=%08h exp 1/48484848", bus.ihit, bus.imemload); else n_pass++;
    tick();
    exp_hit++;
    bus.imemaddr = 32'h4B;
    #1;
    n_checks++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'h4848_4848 || bus.iaddr !== 32'h4C)
      $display("FAIL chg_byteoff got ihit=%0h load=%08h iaddr=%08h exp 1/48484848/0000004c",
               bus.ihit, bus.imemload, bus.iaddr); else n_pass++;
    tick();
    exp_hit++;
    bus.imemREN = 1'b0;
  endtask

  task automatic test_saturation();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    repeat (20) begin
      tick();
      exp_hit++;
    end
    bus.imemREN = 1'b0;
    #1;
    n_checks++; if (bus.hit_count !== 4'(sat(exp_hit)))
      $display("FAIL sat_hit_count got %0d exp %0d", bus.hit_count, sat(exp_hit)); else n_pass++;
    n_checks++; if (bus.miss_count !== 4'(sat(exp_miss)))
      $display("FAIL sat_miss_count got %0d exp %0d", bus.miss_count, sat(exp_miss)); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h100;
    bus.iwait    = 1'b1;
    tick();
    exp_miss++;
    n_checks++; if (bus.iREN !== 1'b1) $display("FAIL rst_pre_iREN got %0h exp 1", bus.iREN); else n_pass++;
    #1;
    nRST = 1'b0;
    #1;
    n_checks++; if (bus.iREN !== 1'b0 || bus.iaddr !== 32'h0)
      $display("FAIL rst_async got iREN=%0h iaddr=%08h exp 0/0", bus.iREN, bus.iaddr); else n_pass++;
    n_checks++; if (bus.hit_count !== 4'd0 || bus.miss_count !== 4'd0)
      $display("FAIL rst_counters got %0d/%0d exp 0/0", bus.hit_count, bus.miss_count); else n_pass++;
    exp_hit  = 0;
    exp_miss = 0;
    tick();
    #2;
    nRST         = 1'b1;
    bus.imemaddr = 32'h40;
    #1;
    n_checks++; if (bus.ihit !== 1'b0 || bus.imemload !== 32'h0)
      $display("FAIL rst_lines_invalid got ihit=%0h load=%08h exp 0/0", bus.ihit, bus.imemload); else n_pass++;
    bus.imemREN = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    exp_hit  = 0;
    exp_miss = 0;
    test_reset();
    test_miss_fill();
    test_conflict();
    test_abort();
    test_addr_change();
    test_saturation();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
